// File: rtl/ad40xx_spi_pkg.sv
// Shared constants, state encoding and helpers for the AD40xx SPI responder.
package ad40xx_spi_pkg;

    localparam logic [7:0] AD40XX_CMD_WR = 8'h14;
    localparam logic [7:0] AD40XX_CMD_RD = 8'h54;

    localparam int CMD_BITS       = 8;
    localparam int REG_FRAME_BITS = 16;
    localparam int BIT_CNT_W      = 5;

    typedef logic [BIT_CNT_W-1:0] bit_cnt_t;

    localparam bit_cnt_t BIT_CNT_MAX = '1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        REG_WR,
        REG_RD
    } state_e;

    function automatic bit_cnt_t bit_cnt_inc(input bit_cnt_t cnt);
        return (cnt == BIT_CNT_MAX) ? cnt : cnt + bit_cnt_t'(1);
    endfunction

    function automatic logic [15:0] sat_inc16(input logic [15:0] val);
        return (val == 16'hFFFF) ? val : val + 16'd1;
    endfunction

endpackage

// File: rtl/ad40xx_spi_sync.sv
// Multi-flop synchronizer for one SPI pin followed by a rise/fall edge detector.
import ad40xx_spi_pkg::*;

module ad40xx_spi_sync #(
    parameter int   STAGES    = 2,
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic resetn,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_q;
    logic [STAGES-1:0] sync_d;
    logic              prev_q;
    logic              prev_d;

    always_comb begin
        sync_d = {sync_q[STAGES-2:0], din};
        prev_d = sync_q[STAGES-1];
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sync_q <= {STAGES{RESET_VAL}};
            prev_q <= RESET_VAL;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign level = sync_q[STAGES-1];
    assign rise  = level & ~prev_q;
    assign fall  = ~level & prev_q;

endmodule

// File: rtl/ad40xx_spi_responder.sv
// AD40xx-style SPI responder: streams conversion samples on SDO and decodes
// 16-bit register write/read frames, all sampled on the oversampling clk.
import ad40xx_spi_pkg::*;

module ad40xx_spi_responder #(
    parameter int         DATA_WIDTH  = 16,
    parameter logic [7:0] CFG_RESET   = 8'hE1,
    parameter int         SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  spi_sclk,
    input  logic                  spi_cs,
    input  logic                  spi_sdi,
    output logic                  spi_sdo,
    output logic                  spi_sdo_t,
    input  logic [DATA_WIDTH-1:0] s_sample_data,
    input  logic                  s_sample_valid,
    output logic                  s_sample_ready,
    output logic [7:0]            cfg_reg,
    output logic                  cfg_wr,
    output logic                  frame_done,
    output logic [15:0]           underrun_cnt
);

    localparam bit_cnt_t DW_CNT   = bit_cnt_t'(DATA_WIDTH);
    localparam bit_cnt_t CMD_LAST = bit_cnt_t'(CMD_BITS - 1);
    localparam bit_cnt_t REG_LAST = bit_cnt_t'(REG_FRAME_BITS - 1);
    localparam int       PAD_BITS = DATA_WIDTH - CMD_BITS - 1;

    logic sclk_rise;
    logic sclk_fall;
    logic sclk_level_unused;
    logic cs_rise;
    logic cs_fall;
    logic cs_level_unused;
    logic sdi_level;
    logic sdi_rise_unused;
    logic sdi_fall_unused;

    // CS resets to "low" so a frame already running when reset releases never
    // produces a falling event; only a fresh high-to-low transition starts a frame.
    ad40xx_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_cs (
        .clk    (clk),
        .resetn (resetn),
        .din    (spi_cs),
        .level  (cs_level_unused),
        .rise   (cs_rise),
        .fall   (cs_fall)
    );

    ad40xx_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
        .clk    (clk),
        .resetn (resetn),
        .din    (spi_sclk),
        .level  (sclk_level_unused),
        .rise   (sclk_rise),
        .fall   (sclk_fall)
    );

    ad40xx_spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sdi (
        .clk    (clk),
        .resetn (resetn),
        .din    (spi_sdi),
        .level  (sdi_level),
        .rise   (sdi_rise_unused),
        .fall   (sdi_fall_unused)
    );

    state_e                state_q,     state_d;
    bit_cnt_t              bit_cnt_q,   bit_cnt_d;
    logic [15:0]           cmd_sr_q,    cmd_sr_d;
    logic [DATA_WIDTH-1:0] shift_out_q, shift_out_d;
    logic [DATA_WIDTH-1:0] shadow_q,    shadow_d;
    logic                  sdo_q,       sdo_d;
    logic                  sdo_t_q,     sdo_t_d;
    logic                  ready_q,     ready_d;
    logic [7:0]            cfg_reg_q,   cfg_reg_d;
    logic                  cfg_wr_q,    cfg_wr_d;
    logic                  done_q,      done_d;
    logic [15:0]           underrun_q,  underrun_d;

    logic [15:0]           cmd_next;
    logic                  cmd_msb_unused;

    assign cmd_next       = {cmd_sr_q[14:0], sdi_level};
    assign cmd_msb_unused = cmd_sr_q[15];

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        cmd_sr_d    = cmd_sr_q;
        shift_out_d = shift_out_q;
        shadow_d    = shadow_q;
        sdo_d       = sdo_q;
        sdo_t_d     = sdo_t_q;
        ready_d     = 1'b0;
        cfg_reg_d   = cfg_reg_q;
        cfg_wr_d    = 1'b0;
        done_d      = 1'b0;
        underrun_d  = underrun_q;

        // CS events win over any sclk event seen in the same clk.
        if (cs_rise) begin
            done_d    = (state_q != IDLE);
            state_d   = IDLE;
            sdo_t_d   = 1'b1;
            sdo_d     = 1'b0;
            bit_cnt_d = '0;
        end else if (cs_fall) begin
            if (state_q == IDLE) begin
                state_d   = SHIFT;
                bit_cnt_d = '0;
                cmd_sr_d  = '0;
                sdo_t_d   = 1'b0;
                if (s_sample_valid) begin
                    shift_out_d = s_sample_data;
                    shadow_d    = s_sample_data;
                    ready_d     = 1'b1;
                    sdo_d       = s_sample_data[DATA_WIDTH-1];
                end else begin
                    shift_out_d = shadow_q;
                    sdo_d       = shadow_q[DATA_WIDTH-1];
                    underrun_d  = sat_inc16(underrun_q);
                end
            end
        end else if (state_q != IDLE) begin
            if (sclk_rise) begin
                bit_cnt_d = bit_cnt_inc(bit_cnt_q);
                cmd_sr_d  = cmd_next;
                case (state_q)
                    SHIFT: begin
                        if (bit_cnt_q == CMD_LAST) begin
                            if (cmd_next[7:0] == AD40XX_CMD_WR) begin
                                state_d = REG_WR;
                            end else if (cmd_next[7:0] == AD40XX_CMD_RD) begin
                                state_d = REG_RD;
                                // Leading pad bit is consumed by the next falling
                                // edge so cfg_reg[7] lands on bit 8.
                                shift_out_d = {1'b0, cfg_reg_q, {PAD_BITS{1'b0}}};
                            end
                        end
                    end
                    REG_WR: begin
                        if (bit_cnt_q == REG_LAST) begin
                            cfg_reg_d = cmd_next[7:0];
                            cfg_wr_d  = 1'b1;
                        end
                    end
                    default: begin
                    end
                endcase
            end
            if (sclk_fall) begin
                shift_out_d = shift_out_q << 1;
                sdo_d       = (bit_cnt_q >= DW_CNT) ? 1'b0 : shift_out_q[DATA_WIDTH-2];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            cmd_sr_q    <= '0;
            shift_out_q <= '0;
            shadow_q    <= '0;
            sdo_q       <= 1'b0;
            sdo_t_q     <= 1'b1;
            ready_q     <= 1'b0;
            cfg_reg_q   <= CFG_RESET;
            cfg_wr_q    <= 1'b0;
            done_q      <= 1'b0;
            underrun_q  <= '0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            cmd_sr_q    <= cmd_sr_d;
            shift_out_q <= shift_out_d;
            shadow_q    <= shadow_d;
            sdo_q       <= sdo_d;
            sdo_t_q     <= sdo_t_d;
            ready_q     <= ready_d;
            cfg_reg_q   <= cfg_reg_d;
            cfg_wr_q    <= cfg_wr_d;
            done_q      <= done_d;
            underrun_q  <= underrun_d;
        end
    end

    assign spi_sdo        = sdo_q;
    assign spi_sdo_t      = sdo_t_q;
    assign s_sample_ready = ready_q;
    assign cfg_reg        = cfg_reg_q;
    assign cfg_wr         = cfg_wr_q;
    assign frame_done     = done_q;
    assign underrun_cnt   = underrun_q;

endmodule

// File: tb/tb_ad40xx_spi_responder.sv
// Self-checking bench: drives mode-0 SPI frames at clk/8 and compares against a
// frame-level reference model of the AD40xx responder.
module tb_ad40xx_spi_responder;

    localparam int         DW      = 16;
    localparam logic [7:0] CMD_WR  = 8'h14;
    localparam logic [7:0] CMD_RD  = 8'h54;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          spi_sclk = 1'b0;
    logic          spi_cs = 1'b1;
    logic          spi_sdi = 1'b0;
    logic          spi_sdo;
    logic          spi_sdo_t;
    logic [DW-1:0] s_sample_data = '0;
    logic          s_sample_valid = 1'b0;
    logic          s_sample_ready;
    logic [7:0]    cfg_reg;
    logic          cfg_wr;
    logic          frame_done;
    logic [15:0]   underrun_cnt;

    ad40xx_spi_responder #(.DATA_WIDTH(DW), .CFG_RESET(8'hE1), .SYNC_STAGES(2)) dut (
        .clk            (clk),
        .resetn         (resetn),
        .spi_sclk       (spi_sclk),
        .spi_cs         (spi_cs),
        .spi_sdi        (spi_sdi),
        .spi_sdo        (spi_sdo),
        .spi_sdo_t      (spi_sdo_t),
        .s_sample_data  (s_sample_data),
        .s_sample_valid (s_sample_valid),
        .s_sample_ready (s_sample_ready),
        .cfg_reg        (cfg_reg),
        .cfg_wr         (cfg_wr),
        .frame_done     (frame_done),
        .underrun_cnt   (underrun_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    int ready_cnt = 0;
    int wr_cnt    = 0;
    int done_cnt  = 0;

    always @(negedge clk) begin
        ready_cnt <= ready_cnt + (s_sample_ready ? 1 : 0);
        wr_cnt    <= wr_cnt + (cfg_wr ? 1 : 0);
        done_cnt  <= done_cnt + (frame_done ? 1 : 0);
    end

    // Reference model state: what the emulated converter should remember.
    logic [7:0]    m_cfg      = 8'hE1;
    logic [DW-1:0] m_last     = '0;
    logic [15:0]   m_underrun = '0;

    initial begin
        #1000000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        n_checks++;
        assert (observed === expected) begin
            n_pass++;
        end else begin
            $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // One chip-select frame; MOSI word is sent MSB first over nbits sclk pulses.
    task automatic applyStimulus(input logic valid, input logic [DW-1:0] data,
                                 input logic [31:0] mosi, input int nbits, input int reset_at,
                                 output logic [31:0] miso, output logic sdo_t_mid,
                                 output logic hiz_after_reset);
        miso            = '0;
        sdo_t_mid       = 1'b1;
        hiz_after_reset = 1'b1;
        @(negedge clk);
        s_sample_valid = valid;
        s_sample_data  = data;
        spi_cs         = 1'b0;
        repeat (8) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            spi_sdi = mosi[nbits-1-i];
            if (i == reset_at) begin
                resetn = 1'b0;
                @(negedge clk);
                resetn = 1'b1;
            end
            repeat (4) @(negedge clk);
            miso[nbits-1-i] = spi_sdo;
            if (i == 0) sdo_t_mid = spi_sdo_t;
            if (reset_at >= 0 && i >= reset_at && spi_sdo_t !== 1'b1) hiz_after_reset = 1'b0;
            spi_sclk = 1'b1;
            repeat (4) @(negedge clk);
            spi_sclk = 1'b0;
        end
        repeat (4) @(negedge clk);
        spi_cs         = 1'b1;
        spi_sdi        = 1'b0;
        s_sample_valid = 1'b0;
        repeat (8) @(negedge clk);
    endtask

    // Frame-level expectation: which sample or register byte each MISO bit carries.
    task automatic model_frame(input logic valid, input logic [DW-1:0] data,
                               input logic [31:0] mosi, input int nbits,
                               output logic [31:0] exp_miso, output logic [31:0] mask,
                               output int exp_ready, output int exp_wr);
        logic [DW-1:0] smp;
        logic [7:0]    cmd;
        logic          b;
        if (valid) begin
            smp       = data;
            m_last    = data;
            exp_ready = 1;
        end else begin
            smp       = m_last;
            exp_ready = 0;
            if (m_underrun != 16'hFFFF) m_underrun = m_underrun + 16'd1;
        end
        cmd      = (nbits >= 8) ? mosi[nbits-1 -: 8] : 8'h00;
        exp_miso = '0;
        mask     = '0;
        exp_wr   = 0;
        for (int i = 0; i < nbits; i++) begin
            if (cmd == CMD_RD && i >= 8) b = (i < 16) ? m_cfg[15-i] : 1'b0;
            else                         b = (i < DW) ? smp[DW-1-i] : 1'b0;
            exp_miso[nbits-1-i] = b;
            mask[nbits-1-i]     = !(cmd == CMD_WR && i >= 8);
        end
        if (cmd == CMD_WR && nbits >= 16) begin
            m_cfg  = mosi[nbits-9 -: 8];
            exp_wr = 1;
        end
    endtask

    task automatic run_frame(input string tag, input logic valid, input logic [DW-1:0] data,
                             input logic [31:0] mosi, input int nbits);
        logic [31:0] exp_miso, mask, miso;
        int          exp_ready, exp_wr, r0, w0, d0;
        logic        sdo_t_mid, hiz_unused;
        model_frame(valid, data, mosi, nbits, exp_miso, mask, exp_ready, exp_wr);
        r0 = ready_cnt;
        w0 = wr_cnt;
        d0 = done_cnt;
        applyStimulus(valid, data, mosi, nbits, -1, miso, sdo_t_mid, hiz_unused);
        checkOutput({tag, "_miso"},     miso & mask, exp_miso & mask);
        checkOutput({tag, "_ready"},    ready_cnt - r0, exp_ready);
        checkOutput({tag, "_cfg_wr"},   wr_cnt - w0, exp_wr);
        checkOutput({tag, "_done"},     done_cnt - d0, 1);
        checkOutput({tag, "_cfg"},      {24'd0, cfg_reg}, {24'd0, m_cfg});
        checkOutput({tag, "_underrun"}, {16'd0, underrun_cnt}, {16'd0, m_underrun});
        checkOutput({tag, "_sdo_t_on"}, {31'd0, sdo_t_mid}, 32'd0);
        checkOutput({tag, "_sdo_t_off"}, {31'd0, spi_sdo_t}, 32'd1);
    endtask

    function automatic logic [31:0] rand_mosi(input int nbits);
        logic [31:0] w;
        logic [7:0]  hdr;
        w = $urandom;
        if (nbits < 32) w = w & ((32'd1 << nbits) - 32'd1);
        hdr = w[nbits-1 -: 8];
        if (hdr == CMD_WR || hdr == CMD_RD) w[nbits-1] = ~w[nbits-1];
        return w;
    endfunction

    initial begin
        logic [31:0] miso;
        logic        sdo_t_mid, hiz_ok;
        int          d0;

        $display("[TB] reset");
        repeat (4) @(negedge clk);
        checkOutput("rst_sdo",      {31'd0, spi_sdo}, 32'd0);
        checkOutput("rst_sdo_t",    {31'd0, spi_sdo_t}, 32'd1);
        checkOutput("rst_ready",    {31'd0, s_sample_ready}, 32'd0);
        checkOutput("rst_cfg",      {24'd0, cfg_reg}, 32'h0000_00E1);
        checkOutput("rst_cfg_wr",   {31'd0, cfg_wr}, 32'd0);
        checkOutput("rst_done",     {31'd0, frame_done}, 32'd0);
        checkOutput("rst_underrun", {16'd0, underrun_cnt}, 32'd0);
        resetn = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("rst_no_done", done_cnt, 0);

        $display("[TB] readout");
        run_frame("readout_a5c3", 1'b1, 16'hA5C3, rand_mosi(16), 16);
        for (int k = 0; k < 4; k++) begin
            int nb;
            nb = int'($urandom_range(16, 32));
            run_frame($sformatf("readout_rand%0d", k), 1'b1, DW'($urandom), rand_mosi(nb), nb);
        end

        $display("[TB] underrun");
        run_frame("underrun_load", 1'b1, 16'h1234, rand_mosi(16), 16);
        run_frame("underrun_1", 1'b0, DW'($urandom), rand_mosi(16), 16);
        run_frame("underrun_2", 1'b0, DW'($urandom), rand_mosi(16), 16);

        $display("[TB] register write/read");
        run_frame("reg_wr", 1'b1, DW'($urandom), 32'h0000_143C, 16);
        run_frame("reg_rd", 1'b1, DW'($urandom), 32'h0000_5400, 16);
        run_frame("reg_rd_long", 1'b1, DW'($urandom), 32'h0054_0000 | 32'($urandom_range(0, 65535)), 24);

        $display("[TB] abort");
        run_frame("abort_wr", 1'b1, DW'($urandom), 32'h0000_014F, 12);
        run_frame("after_abort", 1'b1, DW'($urandom), rand_mosi(16), 16);

        $display("[TB] reset mid-frame");
        d0 = done_cnt;
        applyStimulus(1'b1, DW'($urandom), rand_mosi(16), 16, 5, miso, sdo_t_mid, hiz_ok);
        m_cfg      = 8'hE1;
        m_last     = '0;
        m_underrun = '0;
        checkOutput("midrst_hiz",      {31'd0, hiz_ok}, 32'd1);
        checkOutput("midrst_cfg",      {24'd0, cfg_reg}, 32'h0000_00E1);
        checkOutput("midrst_underrun", {16'd0, underrun_cnt}, 32'd0);
        checkOutput("midrst_no_done",  done_cnt - d0, 0);
        run_frame("post_rst_underrun", 1'b0, DW'($urandom), rand_mosi(16), 16);
        run_frame("post_rst_readout", 1'b1, DW'($urandom), rand_mosi(20), 20);

        $display("[TB] %0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
